// File: rtl/game_pkg.sv
// Shared types for the two-player board game turn controller.
package game_pkg;

    localparam int GAME_BOARD_LEN = 32;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_ROLL = 3'd1,
        S_MOVE      = 3'd2,
        S_CHECK     = 3'd3,
        S_NEXT      = 3'd4,
        S_WIN       = 3'd5
    } game_state_t;

    // Colour results arrive already mapped to a step count by the result manager.
    typedef enum logic [1:0] {
        STEPS_NONE  = 2'd0,
        STEPS_ONE   = 2'd1,
        STEPS_TWO   = 2'd2,
        STEPS_THREE = 2'd3
    } move_steps_t;

endpackage

// File: rtl/step_timer.sv
// Move pace timer: down-counter that ticks once every STEP_TICKS enabled cycles.
module step_timer #(
    parameter int STEP_TICKS = 25_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic tick
);
    localparam int CNT_W = $clog2(STEP_TICKS) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_TICKS - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && !load && (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= CNT_LOAD;
        end else if (enable) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/game_turn_fsm.sv
// Turn sequencer for a two-player board game: roll, animated move, win check.
//
//   state     | meaning
//   IDLE      | waiting for the current player to press roll
//   WAIT_ROLL | capture enabled, waiting for a non-zero result or timeout
//   MOVE      | advancing the current player one square per step tick
//   CHECK     | one cycle: decide win or hand over the turn
//   NEXT      | one cycle: toggle current player
//   WIN       | winner shown until roll_req starts a new game
module game_turn_fsm
    import game_pkg::*;
#(
    parameter int  BOARD_LEN    = GAME_BOARD_LEN,
    parameter int  STEP_TICKS   = 25_000_000,
    parameter int  WAIT_TIMEOUT = 250_000_000,
    localparam int POS_W        = $clog2(BOARD_LEN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             roll_req,
    input  logic             result_ready,
    input  logic [1:0]       movement_steps,
    output logic             capture_en,
    output logic             cur_player,
    output logic [POS_W-1:0] pos_p0,
    output logic [POS_W-1:0] pos_p1,
    output logic             moving,
    output logic             winner_valid,
    output logic             winner_id,
    output logic [2:0]       game_state
);
    localparam int TMO_W = $clog2(WAIT_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(WAIT_TIMEOUT - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(BOARD_LEN - 1);

    game_state_t      state, state_nxt;
    logic [1:0]       steps_left, steps_left_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [POS_W-1:0] pos_p0_nxt, pos_p1_nxt, cur_pos;
    logic             cur_player_nxt, winner_id_nxt;
    logic             timer_load, timer_en, tick, accept;

    assign timer_en   = (state == S_MOVE);
    assign cur_pos    = cur_player ? pos_p1 : pos_p0;
    assign accept     = result_ready && (movement_steps != STEPS_NONE);
    assign game_state = state;

    step_timer #(.STEP_TICKS(STEP_TICKS)) u_step_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (timer_load),
        .enable  (timer_en),
        .tick    (tick)
    );

    always_comb begin
        state_nxt      = state;
        steps_left_nxt = steps_left;
        tmo_cnt_nxt    = tmo_cnt;
        pos_p0_nxt     = pos_p0;
        pos_p1_nxt     = pos_p1;
        cur_player_nxt = cur_player;
        winner_id_nxt  = winner_id;
        timer_load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (roll_req) begin
                    state_nxt   = S_WAIT_ROLL;
                    tmo_cnt_nxt = TMO_LOAD;
                end
            end
            S_WAIT_ROLL: begin
                // An accepted result wins over a timeout landing in the same cycle.
                if (accept) begin
                    state_nxt      = S_MOVE;
                    steps_left_nxt = movement_steps;
                    tmo_cnt_nxt    = '0;
                    timer_load     = 1'b1;
                end else if (tmo_cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt - 1'b1;
                end
            end
            S_MOVE: begin
                if (tick) begin
                    steps_left_nxt = steps_left - 1'b1;
                    if (cur_player) pos_p1_nxt = pos_p1 + 1'b1;
                    else            pos_p0_nxt = pos_p0 + 1'b1;
                    // Stopping on the last square discards any remaining steps.
                    if (steps_left == 2'd1 || cur_pos == POS_LAST - 1'b1) begin
                        state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (cur_pos == POS_LAST) begin
                    state_nxt     = S_WIN;
                    winner_id_nxt = cur_player;
                end else begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                cur_player_nxt = ~cur_player;
                state_nxt      = S_IDLE;
            end
            S_WIN: begin
                if (roll_req) begin
                    state_nxt      = S_IDLE;
                    pos_p0_nxt     = '0;
                    pos_p1_nxt     = '0;
                    cur_player_nxt = 1'b0;
                    winner_id_nxt  = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            steps_left   <= '0;
            tmo_cnt      <= '0;
            pos_p0       <= '0;
            pos_p1       <= '0;
            cur_player   <= 1'b0;
            winner_id    <= 1'b0;
            capture_en   <= 1'b0;
            moving       <= 1'b0;
            winner_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            steps_left   <= steps_left_nxt;
            tmo_cnt      <= tmo_cnt_nxt;
            pos_p0       <= pos_p0_nxt;
            pos_p1       <= pos_p1_nxt;
            cur_player   <= cur_player_nxt;
            winner_id    <= winner_id_nxt;
            capture_en   <= (state_nxt == S_WAIT_ROLL);
            moving       <= (state_nxt == S_MOVE);
            winner_valid <= (state_nxt == S_WIN);
        end
    end

endmodule

// File: tb/tb_game_turn_fsm.sv
// Bench for game_turn_fsm: vector table plus hand sequences, checked through an expectation queue.
module tb_game_turn_fsm;
    localparam int BOARD_LEN    = 8;
    localparam int STEP_TICKS   = 4;
    localparam int WAIT_TIMEOUT = 20;
    localparam int POS_W        = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             roll_req = 1'b0;
    logic             result_ready = 1'b0;
    logic [1:0]       movement_steps = 2'd0;
    logic             capture_en, cur_player, moving, winner_valid, winner_id;
    logic [POS_W-1:0] pos_p0, pos_p1;
    logic [2:0]       game_state;

    game_turn_fsm #(
        .BOARD_LEN    (BOARD_LEN),
        .STEP_TICKS   (STEP_TICKS),
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .roll_req       (roll_req),
        .result_ready   (result_ready),
        .movement_steps (movement_steps),
        .capture_en     (capture_en),
        .cur_player     (cur_player),
        .pos_p0         (pos_p0),
        .pos_p1         (pos_p1),
        .moving         (moving),
        .winner_valid   (winner_valid),
        .winner_id      (winner_id),
        .game_state     (game_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       st;
        logic             pl;
        logic [POS_W-1:0] p0;
        logic [POS_W-1:0] p1;
        logic             cap;
        logic             mov;
        logic             wv;
        logic             wid;
    } obs_t;

    typedef struct {
        string      name;
        logic       roll;
        logic       res;
        logic [1:0] steps;
        int         waitc;
        obs_t       exp;
    } vec_t;

    vec_t  vecs[26];
    obs_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic obs_t ob(input int st, input int pl, input int p0, input int p1,
                                input int cap, input int mov, input int wv, input int wid);
        obs_t o;
        o.st  = 3'(st);
        o.pl  = 1'(pl);
        o.p0  = POS_W'(p0);
        o.p1  = POS_W'(p1);
        o.cap = 1'(cap);
        o.mov = 1'(mov);
        o.wv  = 1'(wv);
        o.wid = 1'(wid);
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d pl=%0d p0=%0d p1=%0d cap=%0b mov=%0b wv=%0b wid=%0b",
                         o.st, o.pl, o.p0, o.p1, o.cap, o.mov, o.wv, o.wid);
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st  = game_state;
        o.pl  = cur_player;
        o.p0  = pos_p0;
        o.p1  = pos_p1;
        o.cap = capture_en;
        o.mov = moving;
        o.wv  = winner_valid;
        o.wid = winner_id;
        return o;
    endfunction

    task automatic set_vec(input int i, input string n, input logic roll, input logic res,
                           input logic [1:0] steps, input int w, input obs_t e);
        vecs[i].name  = n;
        vecs[i].roll  = roll;
        vecs[i].res   = res;
        vecs[i].steps = steps;
        vecs[i].waitc = w;
        vecs[i].exp   = e;
    endtask

    task automatic push_exp(input string n, input obs_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic check_pop();
        obs_t  act, exp;
        string n;
        act = sample();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %s required a queued expectation", fmt(act));
        end else begin
            exp = exp_q.pop_front();
            n   = name_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got %s required %s", n, fmt(act), fmt(exp));
            end
        end
    endtask

    // Drive the pulse at the current negedge, hold for one edge, wait, then compare.
    task automatic apply(input int i);
        roll_req       = vecs[i].roll;
        result_ready   = vecs[i].res;
        movement_steps = vecs[i].steps;
        push_exp(vecs[i].name, vecs[i].exp);
        @(negedge clk);
        roll_req       = 1'b0;
        result_ready   = 1'b0;
        movement_steps = 2'd0;
        repeat (vecs[i].waitc) @(negedge clk);
        check_pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //      idx name                   roll res  steps wait  st pl p0 p1 cap mov wv wid
        set_vec(0,  "idle_after_reset",    0,   0,   0,    0,  ob(0, 0, 0, 0, 0, 0, 0, 0));
        set_vec(1,  "result_in_idle",      0,   1,   2,    2,  ob(0, 0, 0, 0, 0, 0, 0, 0));
        set_vec(2,  "roll_to_wait",        1,   0,   0,    0,  ob(1, 0, 0, 0, 1, 0, 0, 0));
        set_vec(3,  "zero_steps_ignored",  0,   1,   0,    1,  ob(1, 0, 0, 0, 1, 0, 0, 0));
        set_vec(4,  "reroll_in_wait",      1,   0,   0,    1,  ob(1, 0, 0, 0, 1, 0, 0, 0));
        set_vec(5,  "wait_before_timeout", 0,   0,   0,    14, ob(1, 0, 0, 0, 1, 0, 0, 0));
        set_vec(6,  "timeout_to_idle",     0,   0,   0,    0,  ob(0, 0, 0, 0, 0, 0, 0, 0));
        set_vec(7,  "p0_roll",             1,   0,   0,    0,  ob(1, 0, 0, 0, 1, 0, 0, 0));
        set_vec(8,  "p1_roll_a",           1,   0,   0,    0,  ob(1, 1, 3, 0, 1, 0, 0, 0));
        set_vec(9,  "p1_move3_a",          0,   1,   3,    14, ob(0, 0, 3, 3, 0, 0, 0, 0));
        set_vec(10, "p0_roll_b",           1,   0,   0,    0,  ob(1, 0, 3, 3, 1, 0, 0, 0));
        set_vec(11, "p0_move1_b",          0,   1,   1,    6,  ob(0, 1, 4, 3, 0, 0, 0, 0));
        set_vec(12, "p1_roll_c",           1,   0,   0,    0,  ob(1, 1, 4, 3, 1, 0, 0, 0));
        set_vec(13, "p1_move3_c",          0,   1,   3,    14, ob(0, 0, 4, 6, 0, 0, 0, 0));
        set_vec(14, "p0_roll_d",           1,   0,   0,    0,  ob(1, 0, 4, 6, 1, 0, 0, 0));
        set_vec(15, "p0_move1_d",          0,   1,   1,    6,  ob(0, 1, 5, 6, 0, 0, 0, 0));
        set_vec(16, "p1_roll_win",         1,   0,   0,    0,  ob(1, 1, 5, 6, 1, 0, 0, 0));
        set_vec(17, "p1_overshoot_check",  0,   1,   3,    4,  ob(3, 1, 5, 7, 0, 0, 0, 0));
        set_vec(18, "p1_win",              0,   0,   0,    0,  ob(5, 1, 5, 7, 0, 0, 1, 1));
        set_vec(19, "result_in_win",       0,   1,   2,    6,  ob(5, 1, 5, 7, 0, 0, 1, 1));
        set_vec(20, "roll_clears_win",     1,   0,   0,    0,  ob(0, 0, 0, 0, 0, 0, 0, 0));
        set_vec(21, "p0_roll_e",           1,   0,   0,    0,  ob(1, 0, 0, 0, 1, 0, 0, 0));
        set_vec(22, "p0_move3_e",          0,   1,   3,    14, ob(0, 1, 3, 0, 0, 0, 0, 0));
        set_vec(23, "p1_roll_f",           1,   0,   0,    0,  ob(1, 1, 3, 0, 1, 0, 0, 0));
        set_vec(24, "p1_mid_move",         0,   1,   3,    2,  ob(2, 1, 3, 0, 0, 1, 0, 0));
        set_vec(25, "roll_after_reset",    1,   0,   0,    0,  ob(1, 0, 0, 0, 1, 0, 0, 0));

        repeat (3) @(negedge clk);
        push_exp("reset_hold", ob(0, 0, 0, 0, 0, 0, 0, 0));
        check_pop();
        reset_n = 1'b1;

        for (int i = 0; i <= 7; i++) apply(i);

        // Three-step move for player 0, one square every STEP_TICKS, with stray pulses mid-move.
        result_ready   = 1'b1;
        movement_steps = 2'd3;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k == 0) begin
                result_ready   = 1'b0;
                movement_steps = 2'd0;
            end
            push_exp($sformatf("turn_k%0d", k),
                     ob((k < 12) ? 2 : (k == 12) ? 3 : (k == 13) ? 4 : 0,
                        (k == 14) ? 1 : 0,
                        (k >= 12) ? 3 : k / 4,
                        0, 0, (k < 12) ? 1 : 0, 0, 0));
            check_pop();
            if (k == 5) begin
                result_ready   = 1'b1;
                movement_steps = 2'd1;
                roll_req       = 1'b1;
            end
            if (k == 6) begin
                result_ready   = 1'b0;
                movement_steps = 2'd0;
                roll_req       = 1'b0;
            end
        end

        for (int i = 8; i <= 24; i++) apply(i);

        // Reset two cycles into a move must clear everything without a clock edge.
        #1 reset_n = 1'b0;
        #1;
        push_exp("reset_async", ob(0, 0, 0, 0, 0, 0, 0, 0));
        check_pop();
        @(negedge clk);
        @(negedge clk);
        push_exp("reset_held", ob(0, 0, 0, 0, 0, 0, 0, 0));
        check_pop();
        reset_n = 1'b1;
        apply(25);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_turn_fsm.md
GAME_TURN_FSM -- requirements
Module: game_turn_fsm

Interface
REQ-001 SHALL have parameter BOARD_LEN, default 32: number of squares; square BOARD_LEN-1 is the finish square.
REQ-002 SHALL have parameter STEP_TICKS, default 25_000_000: clock cycles per one-square move (animation pace).
REQ-003 SHALL have parameter WAIT_TIMEOUT, default 250_000_000: cycles allowed in WAIT_ROLL before abort.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on posedge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port roll_req, input, 1: single-cycle pulse from debounced player button.
REQ-007 SHALL have port result_ready, input, 1: single-cycle pulse from the color result manager.
REQ-008 SHALL have port movement_steps, input, 2: 0 = none, 1/2/3 = squares; sampled only when result_ready=1.
REQ-009 SHALL have port capture_en, output, 1: high only in WAIT_ROLL; tells the detector path a roll is expected.
REQ-010 SHALL have port cur_player, output, 1: player whose turn it is (0 or 1).
REQ-011 SHALL have ports pos_p0 and pos_p1, output, POS_W = $clog2(BOARD_LEN) each: square index per player.
REQ-012 SHALL have port moving, output, 1: high while in MOVE.
REQ-013 SHALL have port winner_valid, output, 1: high while in WIN; port winner_id, output, 1: winning player.
REQ-014 SHALL have port game_state, output, 3: current state encoding, for debug/display.

Function
REQ-015 SHALL implement states IDLE, WAIT_ROLL, MOVE, CHECK, NEXT, WIN.
REQ-016 IDLE: roll_req -> WAIT_ROLL next cycle; result_ready ignored.
REQ-017 WAIT_ROLL: result_ready with movement_steps != 0 -> latch steps into steps_left, go to MOVE; steps == 0 -> ignored, stay in WAIT_ROLL.
REQ-018 WAIT_ROLL: timeout counter cleared on entry; after WAIT_TIMEOUT cycles with no accepted result -> IDLE, same player, no move.
REQ-019 WAIT_ROLL: roll_req re-pulses SHALL be ignored and SHALL NOT restart the timeout.
REQ-020 MOVE: tick counter loads STEP_TICKS-1 on entry and counts down; at 0, current player's position +1, steps_left -1, counter reloads.
REQ-021 First square advance SHALL occur exactly STEP_TICKS cycles after entering MOVE.
REQ-022 MOVE -> CHECK when steps_left reaches 0 or the position reaches BOARD_LEN-1; position SHALL never exceed BOARD_LEN-1 (overshoot discarded).
REQ-023 result_ready and roll_req SHALL be ignored in MOVE, CHECK, NEXT and WIN, except roll_req in WIN (REQ-026).
REQ-024 CHECK (1 cycle): position == BOARD_LEN-1 -> WIN with winner_id = cur_player; otherwise -> NEXT.
REQ-025 NEXT (1 cycle): cur_player toggles -> IDLE.
REQ-026 WIN: holds winner_valid and positions; roll_req -> clear both positions to 0, cur_player = 0, winner_valid = 0, then IDLE.
REQ-027 Only the current player's position SHALL change during MOVE; the other player's position is held.
REQ-028 Counter widths SHALL be $clog2 of the respective parameter value + 1; no wrap-around permitted.

Reset
REQ-029 reset_n low SHALL asynchronously force state IDLE, pos_p0 = pos_p1 = 0, cur_player = 0, steps_left = 0, all counters 0, capture_en = moving = winner_valid = winner_id = 0.
REQ-030 Reset asserted mid-MOVE SHALL abandon the move; no partial position survives.
REQ-031 The first state transition after deassertion SHALL occur no earlier than the first clk edge with reset_n high.

Structure
REQ-032 SHALL place the state enum, the color/step encoding and the default BOARD_LEN in shared package game_pkg.
REQ-033 SHALL use one sub-module, step_timer (parameter STEP_TICKS; inputs load and enable; output tick), for the MOVE pace counter.
REQ-034 All outputs SHALL be registered, except game_state, which SHALL decode the state register directly.

Verification (STEP_TICKS=4, WAIT_TIMEOUT=20, BOARD_LEN=8)
REQ-035 Basic turn: roll_req, then result_ready with steps=3 -> pos_p0 increments 0->1->2->3 at 4-cycle intervals; cur_player = 1; state IDLE.
REQ-036 Zero and out-of-window results: result_ready in IDLE with steps=2 -> no change; in WAIT_ROLL with steps=0 -> stays in WAIT_ROLL with capture_en = 1.
REQ-037 Timeout: roll_req, then 20 idle cycles -> IDLE, cur_player unchanged, positions unchanged.
REQ-038 Overshoot/win: pos_p1 = 6, steps=3 -> pos_p1 stops at 7; winner_valid = 1, winner_id = 1; result_ready ignored; roll_req -> all positions 0, IDLE.
REQ-039 Reset mid-move: reset_n pulsed low 2 cycles into MOVE with steps=3 -> all outputs at reset values immediately, no clock edge needed.
REQ-040 Move isolation: result_ready and roll_req pulsed during MOVE -> no effect on steps_left or on the other player's position.
